serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial adder that wraps one Fulladder slice with a carry flip-flop and operand/result shift registers.
- Adds two WIDTH-bit operands LSB-first, one bit per clock, using a start/busy/done handshake.
- Sits directly around the Fulladder: its registers feed the slice inputs and consume the slice's sum/carry outputs.
- Gives the ALU path a multi-bit add using a single adder slice.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range is WIDTH >= 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request an add; sampled only in IDLE.
- inA  input  WIDTH  operand A; captured on the accepting edge.
- inB  input  WIDTH  operand B; captured on the accepting edge.
- inCarry  input  1  carry-in; captured on the accepting edge.
- sum  output  WIDTH  registered result; holds until the next completion.
- carry  output  1  registered carry-out; holds until the next completion.
- busy  output  1  high while an add is in progress.
- done  output  1  one-cycle completion pulse.

Interface (already decided):
- One clock (clk).
- Reset is asynchronous and active-high (reset).

Behaviour:
- Reset (asserted at any time, including mid-operation):
  - state=IDLE.
  - sum=0, carry=0, busy=0, done=0.
  - Operand shift registers, partial-sum register, carry flip-flop and bit counter all cleared.
  - Any in-flight add is discarded; no done pulse is produced for it.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, done=0.
  - Rising edge with start=1 (the accept edge, edge 0):
    - regA<=inA, regB<=inB, cff<=inCarry, count<=0, state<=SHIFT.
  - start=0 keeps the block in IDLE.
- SHIFT:
  - busy=1.
  - Fulladder slice inputs: regA[0], regB[0], cff. Slice outputs: s and c.
  - Each edge:
    - regA and regB shift right by one (zero-fill).
    - Partial-sum register shifts right with s inserted at the MSB.
    - cff<=c; count<=count+1.
  - On the edge where count==WIDTH-1 (the WIDTH-th SHIFT edge):
    - sum<=final partial sum (bit 0 is the first bit computed).
    - carry<=c.
    - state<=DONE.
- DONE:
  - busy=0, done=1 for exactly one cycle.
  - Next edge: state<=IDLE.
- Latency: done is high in the cycle after edge WIDTH, counted from accept edge 0. Total WIDTH+1 cycles per add, including the DONE cycle.
- start in SHIFT or DONE is ignored: no restart, operands not recaptured. start must be re-presented while in IDLE.
- Back-to-back: start held high continuously → a new add is accepted on the first IDLE edge after DONE. Throughput is one add per WIDTH+2 cycles.
- sum/carry are only updated at completion. They hold the previous result throughout SHIFT, so intermediate bits are never visible.
- Arithmetic is modulo 2^WIDTH; overflow is reported only via carry.
- WIDTH=1: a single SHIFT edge, then DONE.
- Changing inA/inB/inCarry after the accept edge has no effect on the running add.

Test Plan:
- Reset → sum=0x00, carry=0, busy=0, done=0. Then start with inA=0x0F, inB=0x01, inCarry=0 (WIDTH=8) → busy high for 8 cycles; done pulses once 8 edges after accept; sum=0x10, carry=0.
- inA=0xFF, inB=0x01, inCarry=0 → sum=0x00, carry=1. Then inA=0x00, inB=0x00, inCarry=1 → sum=0x01, carry=0.
- inA=0xAA, inB=0x55, inCarry=1 → sum=0x00, carry=1. While busy, pulse start with inA=0x01, inB=0x01 → ignored, result unchanged, single done pulse.
- Start 0x12+0x34, assert reset for 1 cycle at SHIFT edge 4 → sum=0, carry=0, busy=0, no done pulse. Then start 0x12+0x34, cin=0 → sum=0x46, carry=0.
- start held high continuously with inA=0x80, inB=0x80, inCarry=0 → done pulses every 10 cycles; sum=0x00, carry=1 each time. sum stays stable between pulses.
- WIDTH=1 build: inA=1, inB=1, inCarry=1 → done 1 edge after accept; sum=1, carry=1.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder built around a single full-adder slice with a carry flop.
// Latency: done pulses WIDTH+1 cycles after the accepting edge; one add per WIDTH+2 cycles with start held.
// Backpressure: none; start is only sampled in IDLE and ignored while busy or done.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             inCarry,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             busy,
    output logic             done
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] reg_a_q, reg_a_d;
    logic [WIDTH-1:0] reg_b_q, reg_b_d;
    logic [WIDTH-1:0] psum_q, psum_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cff_q, cff_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    count_q, count_d;

    logic             fa_s, fa_c;
    logic [WIDTH-1:0] psum_next;

    full_adder u_fa (
        .a    (reg_a_q[0]),
        .b    (reg_b_q[0]),
        .cin  (cff_q),
        .s    (fa_s),
        .cout (fa_c)
    );

    // New bit enters at the MSB so the first computed bit ends up at bit 0.
    assign psum_next = (psum_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

    always_comb begin
        state_d = state_q;
        reg_a_d = reg_a_q;
        reg_b_d = reg_b_q;
        psum_d  = psum_q;
        sum_d   = sum_q;
        cff_d   = cff_q;
        carry_d = carry_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    reg_a_d = inA;
                    reg_b_d = inB;
                    cff_d   = inCarry;
                    count_d = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                reg_a_d = reg_a_q >> 1;
                reg_b_d = reg_b_q >> 1;
                psum_d  = psum_next;
                cff_d   = fa_c;
                count_d = count_q + CW'(1);
                if (count_q == LAST) begin
                    sum_d   = psum_next;
                    carry_d = fa_c;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            reg_a_q <= '0;
            reg_b_q <= '0;
            psum_q  <= '0;
            sum_q   <= '0;
            cff_q   <= 1'b0;
            carry_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            reg_a_q <= reg_a_d;
            reg_b_q <= reg_b_d;
            psum_q  <= psum_d;
            sum_q   <= sum_d;
            cff_q   <= cff_d;
            carry_q <= carry_d;
            count_q <= count_d;
        end
    end

    assign sum   = sum_q;
    assign carry = carry_q;
    assign busy  = (state_q == SHIFT);
    assign done  = (state_q == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 and WIDTH=1 instances, vector table, random adds, corner sequences.
module tb_serial_adder;
    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] in_a, in_b;
    logic       in_cin;
    logic [7:0] sum8;
    logic       carry8, busy8, done8;

    logic       start1;
    logic [0:0] a1, b1;
    logic       cin1;
    logic [0:0] sum1;
    logic       carry1, busy1, done1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start),
        .inA(in_a), .inB(in_b), .inCarry(in_cin),
        .sum(sum8), .carry(carry8), .busy(busy8), .done(done8)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1),
        .inA(a1), .inB(b1), .inCarry(cin1),
        .sum(sum1), .carry(carry1), .busy(busy1), .done(done1)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        bit         poke;
        logic [7:0] exp_s;
        logic       exp_c;
    } vec_t;

    vec_t tbl[7];

    function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b, input logic cin);
        return {1'b0, a} + {1'b0, b} + 9'(cin);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic do_add(input string nm, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input bit poke,
                          input logic [7:0] es, input logic ec);
        int         lat;
        int         bcnt;
        bit         hold_ok;
        bit         idle_ok;
        logic [7:0] ps;
        logic       pc;
        logic [7:0] got_s;
        logic       got_c;
        @(negedge clk);
        ps = sum8;
        pc = carry8;
        in_a = a; in_b = b; in_cin = cin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_a = 8'($urandom); in_b = 8'($urandom); in_cin = 1'($urandom);
        lat = 0; bcnt = 0; hold_ok = 1'b1;
        while (done8 !== 1'b1 && lat < 40) begin
            if (busy8 === 1'b1) bcnt++;
            if (sum8 !== ps || carry8 !== pc) hold_ok = 1'b0;
            start = (poke && lat == 3);
            if (poke && lat == 3) begin
                in_a = 8'h01; in_b = 8'h01;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        got_s = sum8;
        got_c = carry8;
        chk({nm, "/latency"}, lat, 8);
        chk({nm, "/busy_cycles"}, bcnt, 8);
        chk({nm, "/hold_during_shift"}, hold_ok, 1);
        chk({nm, "/busy_at_done"}, busy8, 0);
        chk({nm, "/sum"}, got_s, es);
        chk({nm, "/carry"}, got_c, ec);
        idle_ok = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done8 !== 1'b0 || busy8 !== 1'b0) idle_ok = 1'b0;
        end
        chk({nm, "/single_pulse_then_idle"}, idle_ok, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int         pulses[$];
        bit         stable_ok;
        bit         quiet_ok;
        logic [8:0] m;
        logic [1:0] m1;
        logic [7:0] ra, rb;
        logic       rc;

        tbl[0] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1};
        tbl[2] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0};
        tbl[3] = '{8'hAA, 8'h55, 1'b1, 1'b1, 8'h00, 1'b1};
        tbl[4] = '{8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0};
        tbl[5] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1};
        tbl[6] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1};

        reset = 1'b1; start = 1'b0; in_a = 8'h00; in_b = 8'h00; in_cin = 1'b0;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset/sum", sum8, 8'h00);
        chk("reset/carry", carry8, 0);
        chk("reset/busy", busy8, 0);
        chk("reset/done", done8, 0);
        chk("reset/w1_sum", sum1, 0);
        chk("reset/w1_done", done1, 0);
        reset = 1'b0;

        // start low keeps the block idle
        repeat (3) @(negedge clk);
        chk("idle/busy", busy8, 0);
        chk("idle/done", done8, 0);

        for (int i = 0; i < 7; i++)
            do_add($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].poke,
                   tbl[i].exp_s, tbl[i].exp_c);

        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            m = model8(ra, rb, rc);
            do_add($sformatf("rand%0d", i), ra, rb, rc, 1'b0, m[7:0], m[8]);
        end

        // reset in the middle of an add, just before SHIFT edge 4
        do_add("pre_reset", 8'hF0, 8'h0F, 1'b0, 1'b0, 8'hFF, 1'b0);
        @(negedge clk);
        in_a = 8'h12; in_b = 8'h34; in_cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midreset/sum", sum8, 8'h00);
        chk("midreset/carry", carry8, 0);
        chk("midreset/busy", busy8, 0);
        chk("midreset/done", done8, 0);
        @(negedge clk);
        reset = 1'b0;
        quiet_ok = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (done8 !== 1'b0 || busy8 !== 1'b0) quiet_ok = 1'b0;
        end
        chk("midreset/no_done", quiet_ok, 1);
        do_add("after_reset", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0);

        // start held high: back-to-back adds
        @(negedge clk);
        in_a = 8'h80; in_b = 8'h80; in_cin = 1'b0; start = 1'b1;
        stable_ok = 1'b1;
        for (int t = 1; t <= 45; t++) begin
            @(negedge clk);
            if (done8 === 1'b1) begin
                pulses.push_back(t);
                chk($sformatf("b2b/sum@%0d", t), sum8, 8'h00);
                chk($sformatf("b2b/carry@%0d", t), carry8, 1);
            end
            if (pulses.size() > 0 && (sum8 !== 8'h00 || carry8 !== 1'b1)) stable_ok = 1'b0;
        end
        start = 1'b0;
        chk("b2b/pulse_count", pulses.size(), 4);
        chk("b2b/first_pulse", (pulses.size() > 0) ? pulses[0] : -1, 9);
        for (int k = 1; k < pulses.size(); k++)
            chk($sformatf("b2b/interval%0d", k), pulses[k] - pulses[k-1], 10);
        chk("b2b/sum_stable", stable_ok, 1);
        repeat (15) @(negedge clk);

        // WIDTH=1 instance
        for (int i = 0; i < 2; i++) begin
            a1 = 1'b1; b1 = (i == 0) ? 1'b1 : 1'b0; cin1 = (i == 0) ? 1'b1 : 1'b0;
            m1 = 2'(a1) + 2'(b1) + 2'(cin1);
            start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
            chk($sformatf("w1_%0d/busy", i), busy1, 1);
            chk($sformatf("w1_%0d/done_early", i), done1, 0);
            @(negedge clk);
            chk($sformatf("w1_%0d/done", i), done1, 1);
            chk($sformatf("w1_%0d/sum", i), sum1, m1[0]);
            chk($sformatf("w1_%0d/carry", i), carry1, m1[1]);
            @(negedge clk);
            chk($sformatf("w1_%0d/done_fall", i), done1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
